// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encodings and 8N1 frame geometry.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DEF_CLKS_PER_BIT = 434;
    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
// Storage is not reset; the head reads as zero whenever the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a show-ahead byte FIFO,
// with sticky overrun and framing-error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, rxs_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic             ferr_set;
    logic             ovr_set;
    logic             overrun_q, frame_err_q;
    logic             fifo_empty, fifo_full, pop;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line that is high again at mid-start was only a glitch.
                    state_d = rxs_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                    push_d   = rxs_q;
                    ferr_set = !rxs_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (rst) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            push_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            push_q  <= push_d;
            // Error events take priority over a same-cycle clear.
            if (ovr_set)      overrun_q <= 1'b1;
            else if (clr_err) overrun_q <= 1'b0;
            if (ferr_set)     frame_err_q <= 1'b1;
            else if (clr_err) frame_err_q <= 1'b0;
        end
    end

    assign pop     = rd_en && !fifo_empty;
    assign ovr_set = push_q && fifo_full && !pop;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push_q),
        .pop  (pop),
        .din  (shift_q),
        .dout (rx_data),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign rx_valid  = !fifo_empty;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int lat;

    uart_rx #(
        .CLKS_PER_BIT(16),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rd_en    (rd_en),
        .clr_err  (clr_err),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first ncyc cycles of a frame (start, 8 data LSB first, stop).
    task automatic drive_frame(input logic [7:0] b, input logic stop_v, input int ncyc);
        int slot;
        for (int i = 0; i < ncyc; i++) begin
            slot = i / 16;
            if (slot == 0)      rx = 1'b0;
            else if (slot <= 8) rx = b[slot-1];
            else                rx = stop_v;
            tick(1);
        end
    endtask

    task automatic send(input logic [7:0] b);
        drive_frame(b, 1'b1, 160);
        rx = 1'b1;
        tick(4);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
        chk({tag, "_data"}, 32'(rx_data), 32'(exp));
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);

        // Single frame with latency measurement from the start edge.
        tick(5);
        lat = 0;
        fork
            drive_frame(8'hA5, 1'b1, 160);
            begin
                while (!rx_valid && lat < 300) begin
                    tick(1);
                    lat++;
                end
            end
        join
        rx = 1'b1;
        chk("a5_latency", 32'(lat), 32'd156);
        chk("a5_ovr", 32'(overrun), 32'd0);
        chk("a5_ferr", 32'(frame_err), 32'd0);
        pop_chk("a5", 8'hA5);
        chk("a5_empty", 32'(rx_valid), 32'd0);

        // Start glitch, then a normal frame proves the FSM is idle again.
        tick(5);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        chk("glitch_ferr", 32'(frame_err), 32'd0);
        send(8'h5A);
        pop_chk("after_glitch", 8'h5A);

        // Stop bit held low.
        drive_frame(8'h3C, 1'b0, 160);
        rx = 1'b1;
        tick(30);
        chk("ferr_set", 32'(frame_err), 32'd1);
        chk("ferr_valid", 32'(rx_valid), 32'd0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("ferr_clr", 32'(frame_err), 32'd0);

        // Overrun: five bytes into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) send(8'(i));
        chk("ovr_set", 32'(overrun), 32'd1);
        pop_chk("ovr_b1", 8'h01);
        pop_chk("ovr_b2", 8'h02);
        pop_chk("ovr_b3", 8'h03);
        pop_chk("ovr_b4", 8'h04);
        chk("ovr_empty", 32'(rx_valid), 32'd0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Full FIFO: push of 0x15 coincides with a pop.
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i));
        tick(1);
        fork
            drive_frame(8'h15, 1'b1, 160);
            begin
                tick(155);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
            end
        join
        rx = 1'b1;
        tick(2);
        chk("pp_ovr", 32'(overrun), 32'd0);
        pop_chk("pp_b2", 8'h12);
        pop_chk("pp_b3", 8'h13);
        pop_chk("pp_b4", 8'h14);
        pop_chk("pp_b5", 8'h15);
        chk("pp_empty", 32'(rx_valid), 32'd0);

        // Reset in mid data bit 4 with a stored byte and a sticky flag pending.
        drive_frame(8'h3C, 1'b0, 160);
        rx = 1'b1;
        tick(30);
        send(8'h66);
        chk("pre_rst_ferr", 32'(frame_err), 32'd1);
        chk("pre_rst_valid", 32'(rx_valid), 32'd1);
        drive_frame(8'h77, 1'b1, 88);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        rx = 1'b1;
        tick(1);
        chk("mid_rst_data", 32'(rx_data), 32'd0);
        chk("mid_rst_valid", 32'(rx_valid), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        tick(20);
        send(8'h12);
        chk("post_rst_ferr", 32'(frame_err), 32'd0);
        pop_chk("post_rst", 8'h12);
        chk("post_rst_empty", 32'(rx_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
